// File: rtl/sodor_mem_pkg.sv
// rtl/sodor_mem_pkg.sv - shared types and constants for the 3-stage core memory arbiter
package sodor_mem_pkg;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_e;

  localparam logic       M_XRD = 1'b0;
  localparam logic       M_XWR = 1'b1;
  localparam logic [2:0] MT_WU = 3'd7;

  localparam int TRK_ADDR_W = 32;

  typedef struct packed {
    src_e                  src;
    logic [TRK_ADDR_W-1:0] addr;
  } trk_entry_t;

endpackage

// File: rtl/sodor_req_tracker.sv
// rtl/sodor_req_tracker.sv - in-order FIFO of outstanding {src, addr} requests
module sodor_req_tracker
  import sodor_mem_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  trk_entry_t       push_entry_i,
  input  logic             pop_i,
  output trk_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  trk_entry_t       mem_q [DEPTH];
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fullness is judged on the registered count, so a pop never frees a slot for a push in the same cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/sodor_mem_arbiter_3stage.sv
// rtl/sodor_mem_arbiter_3stage.sv - shares one memory master port between fetch and data ports
module sodor_mem_arbiter_3stage
  import sodor_mem_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = TRK_ADDR_W,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_imem_req_valid,
  output logic              io_imem_req_ready,
  input  logic [ADDR_W-1:0] io_imem_req_bits_addr,
  output logic              io_imem_resp_valid,
  output logic [DATA_W-1:0] io_imem_resp_bits_data,
  input  logic              io_dmem_req_valid,
  output logic              io_dmem_req_ready,
  input  logic [ADDR_W-1:0] io_dmem_req_bits_addr,
  input  logic [DATA_W-1:0] io_dmem_req_bits_data,
  input  logic              io_dmem_req_bits_fcn,
  input  logic [2:0]        io_dmem_req_bits_typ,
  output logic              io_dmem_resp_valid,
  output logic [DATA_W-1:0] io_dmem_resp_bits_data,
  output logic              io_mem_req_valid,
  input  logic              io_mem_req_ready,
  output logic [ADDR_W-1:0] io_mem_req_bits_addr,
  output logic [DATA_W-1:0] io_mem_req_bits_data,
  output logic              io_mem_req_bits_fcn,
  output logic [2:0]        io_mem_req_bits_typ,
  input  logic              io_mem_resp_valid,
  input  logic [DATA_W-1:0] io_mem_resp_bits_data,
  output logic [ADDR_W-1:0] io_respAddress,
  output logic              io_busy,
  output logic              io_err
);

  localparam int                  CNT_W      = $clog2(DEPTH + 1);
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_q, err_d;
  logic                full, empty;
  logic [CNT_W-1:0]    count;
  trk_entry_t          head, push_entry;
  src_e                grant_src;
  logic                force_imem, req_open, issue, pop;

  sodor_req_tracker #(.DEPTH(DEPTH)) u_tracker (
    .clock        (clock),
    .reset        (reset),
    .push_i       (issue),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    force_imem = io_imem_req_valid && (starve_q == STARVE_MAX);
    grant_src  = (io_dmem_req_valid && !force_imem) ? SRC_DMEM : SRC_IMEM;
    // Reset gates the request side directly so outputs drop in the same instant reset rises.
    req_open   = !full && !reset;

    io_mem_req_valid = (io_imem_req_valid || io_dmem_req_valid) && req_open;
    if (grant_src == SRC_DMEM) begin
      io_mem_req_bits_addr = io_dmem_req_bits_addr;
      io_mem_req_bits_data = io_dmem_req_bits_data;
      io_mem_req_bits_fcn  = io_dmem_req_bits_fcn;
      io_mem_req_bits_typ  = io_dmem_req_bits_typ;
    end else begin
      io_mem_req_bits_addr = io_imem_req_bits_addr;
      io_mem_req_bits_data = '0;
      io_mem_req_bits_fcn  = M_XRD;
      io_mem_req_bits_typ  = MT_WU;
    end

    io_dmem_req_ready = (grant_src == SRC_DMEM) && io_mem_req_ready && req_open;
    io_imem_req_ready = (grant_src == SRC_IMEM) && io_imem_req_valid && io_mem_req_ready && req_open;

    issue      = io_mem_req_valid && io_mem_req_ready;
    push_entry = '{src: grant_src, addr: TRK_ADDR_W'(io_mem_req_bits_addr)};

    starve_d = starve_q;
    if (!io_imem_req_valid || (issue && grant_src == SRC_IMEM)) starve_d = '0;
    else if (starve_q != STARVE_MAX)                            starve_d = starve_q + 1'b1;

    pop                    = io_mem_resp_valid && !empty;
    io_imem_resp_valid     = pop && (head.src == SRC_IMEM);
    io_dmem_resp_valid     = pop && (head.src == SRC_DMEM);
    io_imem_resp_bits_data = io_mem_resp_bits_data;
    io_dmem_resp_bits_data = io_mem_resp_bits_data;

    err_d          = err_q || (io_mem_resp_valid && empty);
    io_err         = err_q;
    io_busy        = (count != '0);
    io_respAddress = empty ? '0 : ADDR_W'(head.addr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule
